// File: rtl/adc_stream_pkg.sv
// Shared state encoding, frame geometry and default header/gain constants
// for the ADC frame streamer.
package adc_stream_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_AMP_LOAD = 3'd1,
        S_AMP_WAIT = 3'd2,
        S_ARM      = 3'd3,
        S_WAIT_EOC = 3'd4,
        S_SEND     = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    localparam logic [7:0] DEF_SYNC = 8'hA5;
    localparam logic [7:0] DEF_GAIN = 8'h11;

    // SYNC + SEQ + MSB/LSB per channel + checksum
    function automatic int frame_len(input int num_ch);
        return 2 * num_ch + 3;
    endfunction

endpackage

// File: rtl/frame_serializer.sv
// Holds one captured conversion and writes it to the UART FIFO as a framed,
// XOR-checksummed byte stream, stalling while the FIFO reports full.
module frame_serializer
    import adc_stream_pkg::*;
#(
    parameter int         NUM_CH = 2,
    parameter int         DATA_W = 14,
    parameter logic [7:0] SYNC   = DEF_SYNC
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     load,
    input  logic [7:0]               seq,
    input  logic [NUM_CH*DATA_W-1:0] adc_data,
    input  logic                     tx_full,
    output logic                     wr_uart,
    output logic [7:0]               w_data,
    output logic                     last
);

    localparam int LEN   = frame_len(NUM_CH);
    localparam int IDX_W = 4;

    logic [NUM_CH*DATA_W-1:0] shadow_p0;
    logic [7:0]               seq_p0;
    logic [IDX_W-1:0]         idx_p0;
    logic                     active_p0;
    logic [7:0]               cs_p0;

    logic [IDX_W-1:0]         pos;
    logic [NUM_CH*DATA_W-1:0] sh_shift;
    logic [DATA_W-1:0]        sample;
    logic [7:0]               byte_nx;

    // Byte mux: index 2.. walks channels as MSB/LSB pairs
    always_comb begin
        pos      = idx_p0 - IDX_W'(2);
        sh_shift = shadow_p0 >> (32'(pos >> 1) * DATA_W);
        sample   = sh_shift[DATA_W-1:0];
        byte_nx  = SYNC;
        if (idx_p0 == IDX_W'(0))
            byte_nx = SYNC;
        else if (idx_p0 == IDX_W'(1))
            byte_nx = seq_p0;
        else if (idx_p0 == IDX_W'(LEN - 1))
            byte_nx = cs_p0;
        else if (!pos[0])
            byte_nx = 8'(sample >> 8);
        else
            byte_nx = sample[7:0];
    end

    assign last = active_p0 && !tx_full && (idx_p0 == IDX_W'(LEN - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            active_p0 <= 1'b0;
            idx_p0    <= '0;
            cs_p0     <= '0;
            wr_uart   <= 1'b0;
            w_data    <= '0;
        end else begin
            wr_uart <= 1'b0;
            if (load) begin
                active_p0 <= 1'b1;
                idx_p0    <= '0;
                cs_p0     <= '0;
            end else if (active_p0 && !tx_full) begin
                wr_uart <= 1'b1;
                w_data  <= byte_nx;
                cs_p0   <= cs_p0 ^ byte_nx;
                idx_p0  <= idx_p0 + IDX_W'(1);
                if (last)
                    active_p0 <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            shadow_p0 <= adc_data;
            seq_p0    <= seq;
        end
    end

endmodule

// File: rtl/adc_frame_streamer.sv
// Session sequencer: loads amp gain, keeps the ADC converting, decimates
// end-of-conversion events and hands captured samples to the serializer.
module adc_frame_streamer
    import adc_stream_pkg::*;
#(
    parameter int         NUM_CH  = 2,
    parameter int         DATA_W  = 14,
    parameter logic [7:0] GAIN    = DEF_GAIN,
    parameter logic [7:0] SYNC    = DEF_SYNC,
    parameter int         DECIM_W = 8,
    parameter int         CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic [DECIM_W-1:0]       decim,
    input  logic [CNT_W-1:0]         frame_limit,
    output logic                     amp_load,
    output logic [7:0]               amp_data,
    input  logic                     amp_load_ok,
    output logic                     adc_conv,
    input  logic                     adc_end_conv,
    input  logic [NUM_CH*DATA_W-1:0] adc_data,
    input  logic                     tx_full,
    output logic                     wr_uart,
    output logic [7:0]               w_data,
    output logic                     busy,
    output logic                     overrun,
    output logic [2:0]               state_dbg
);

    state_t               state, state_n;
    logic                 eoc_q, eoc_rise;
    logic                 stop_pend, stop_any;
    logic [DECIM_W-1:0]   dec_n, dec_cnt;
    logic [CNT_W-1:0]     limit_r, frame_cnt;
    logic [7:0]           seq;
    logic                 dec_hit, limit_hit;
    logic                 ser_load, ser_last;

    assign eoc_rise  = adc_end_conv && !eoc_q;
    assign stop_any  = stop || stop_pend;
    assign dec_hit   = (dec_cnt == dec_n - DECIM_W'(1));
    assign limit_hit = (limit_r != '0) && (frame_cnt == limit_r - CNT_W'(1));

    assign amp_load  = (state == S_AMP_LOAD);
    assign adc_conv  = (state == S_ARM) || (state == S_WAIT_EOC) || (state == S_SEND);
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    always_comb begin
        state_n  = state;
        ser_load = 1'b0;
        case (state)
            S_IDLE:     if (start) state_n = S_AMP_LOAD;
            S_AMP_LOAD: if (stop_any) state_n = S_DONE;
                        else if (amp_load_ok) state_n = S_ARM;
                        else state_n = S_AMP_WAIT;
            S_AMP_WAIT: if (stop_any) state_n = S_DONE;
                        else if (amp_load_ok) state_n = S_ARM;
            S_ARM:      state_n = stop_any ? S_DONE : S_WAIT_EOC;
            S_WAIT_EOC: if (stop_any) state_n = S_DONE;
                        else if (eoc_rise && dec_hit) begin
                            state_n  = S_SEND;
                            ser_load = 1'b1;
                        end
            // A frame in flight always completes; stop only takes effect after it
            S_SEND:     if (ser_last) state_n = (stop_any || limit_hit) ? S_DONE : S_WAIT_EOC;
            S_DONE:     state_n = S_IDLE;
            default:    state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            eoc_q     <= 1'b0;
            stop_pend <= 1'b0;
            dec_n     <= DECIM_W'(1);
            dec_cnt   <= '0;
            limit_r   <= '0;
            frame_cnt <= '0;
            seq       <= '0;
            overrun   <= 1'b0;
            amp_data  <= '0;
        end else begin
            state <= state_n;
            eoc_q <= adc_end_conv;

            if (state == S_IDLE)
                stop_pend <= 1'b0;
            else if (stop)
                stop_pend <= 1'b1;

            if (state == S_IDLE && start) begin
                dec_n     <= (decim == '0) ? DECIM_W'(1) : decim;
                limit_r   <= frame_limit;
                dec_cnt   <= '0;
                frame_cnt <= '0;
                overrun   <= 1'b0;
                amp_data  <= GAIN;
            end

            // Edges arriving mid-frame still advance decimation; a completed period is dropped
            if (eoc_rise && ((state == S_WAIT_EOC && !stop_any) || state == S_SEND)) begin
                dec_cnt <= dec_hit ? '0 : dec_cnt + DECIM_W'(1);
                if (state == S_SEND && dec_hit)
                    overrun <= 1'b1;
            end

            if (state == S_SEND && ser_last) begin
                seq       <= seq + 8'd1;
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end

    frame_serializer #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .SYNC   (SYNC)
    ) u_ser (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (ser_load),
        .seq      (seq),
        .adc_data (adc_data),
        .tx_full  (tx_full),
        .wr_uart  (wr_uart),
        .w_data   (w_data),
        .last     (ser_last)
    );

endmodule
